// File: rtl/cpu_pkg.sv
// Shared types for the data-memory arbiter: FSM state and port-owner encodings.
package cpu_pkg;

    typedef enum logic [1:0] {
        CPU_PRI,
        IO_BURST,
        YIELD
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_IO
    } arb_owner_t;

    localparam int unsigned STAT_WIDTH = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int unsigned      Width = 4,
    parameter logic [Width-1:0] Limit = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != Limit)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU priority with an I/O starvation guard and a burst cap.
// Defining DMEM_ARB_STATS_EN adds saturating statCpuStall / statIoBeats outputs.
module dmem_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned STARVELIMIT = 8,
    parameter int unsigned BURSTMAX    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpuReq,
    input  logic                  cpuWe,
    input  logic [WIDTH-1:0]      cpuAddr,
    input  logic [WIDTH-1:0]      cpuWData,
    output logic                  cpuStall,
    output logic [WIDTH-1:0]      cpuRData,
    input  logic                  ioReq,
    input  logic                  ioWe,
    input  logic [WIDTH-1:0]      ioAddr,
    input  logic [WIDTH-1:0]      ioWData,
    output logic                  ioGnt,
    output logic                  ioRValid,
    output logic [WIDTH-1:0]      ioRData,
    output logic                  memWe,
    output logic [WIDTH-1:0]      memAddr,
    output logic [WIDTH-1:0]      memWData,
`ifdef DMEM_ARB_STATS_EN
    output logic [STAT_WIDTH-1:0] statCpuStall,
    output logic [STAT_WIDTH-1:0] statIoBeats,
`endif
    input  logic [WIDTH-1:0]      memRData
);

    localparam int unsigned SW = $clog2(STARVELIMIT + 1);
    localparam int unsigned BW = $clog2(BURSTMAX + 1);

    arb_state_t    state_q, state_d;
    arb_owner_t    owner;
    logic [SW-1:0] starve_cnt;
    logic [BW-1:0] burst_cnt;
    logic          starved, burst_last, io_beat, rd_io_q;

    assign starved    = (starve_cnt == SW'(STARVELIMIT));
    // The beat that fills the cap hands the next cycle back to the CPU.
    assign burst_last = cpuReq && (burst_cnt == BW'(BURSTMAX - 1));
    assign io_beat    = (owner == OWN_IO) && ioReq;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= CPU_PRI;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CPU_PRI: begin
                if (ioReq && (starved || !cpuReq)) begin
                    state_d = burst_last ? YIELD : IO_BURST;
                end
            end
            IO_BURST: begin
                if (!ioReq) begin
                    state_d = CPU_PRI;
                end else if (burst_last) begin
                    state_d = YIELD;
                end
            end
            YIELD:   state_d = CPU_PRI;
            default: state_d = CPU_PRI;
        endcase
    end

    always_comb begin
        owner = OWN_NONE;
        unique case (state_q)
            CPU_PRI: begin
                if (ioReq && starved) begin
                    owner = OWN_IO;
                end else if (cpuReq) begin
                    owner = OWN_CPU;
                end else if (ioReq) begin
                    owner = OWN_IO;
                end
            end
            IO_BURST: begin
                if (ioReq) begin
                    owner = OWN_IO;
                end else if (cpuReq) begin
                    owner = OWN_CPU;
                end
            end
            YIELD: begin
                if (cpuReq) begin
                    owner = OWN_CPU;
                end
            end
            default: owner = OWN_NONE;
        endcase
        // Nobody touches the port while reset is asserted.
        if (!reset) begin
            owner = OWN_NONE;
        end
    end

    assign ioGnt    = (owner == OWN_IO);
    assign cpuStall = reset && cpuReq && (owner != OWN_CPU);
    assign memWe    = (owner == OWN_IO) ? ioWe : ((owner == OWN_CPU) ? cpuWe : 1'b0);
    assign memAddr  = (owner == OWN_IO) ? ioAddr : cpuAddr;
    assign memWData = (owner == OWN_IO) ? ioWData : cpuWData;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_io_q <= 1'b0;
        end else begin
            rd_io_q <= io_beat && !ioWe;
        end
    end

    assign ioRValid = rd_io_q;
    assign ioRData  = memRData;
    assign cpuRData = memRData;

    sat_counter #(
        .Width (SW),
        .Limit (SW'(STARVELIMIT))
    ) u_starve_cnt (
        .clk_i  (clock),
        .rst_ni (reset),
        .inc_i  (ioReq && !ioGnt),
        .clr_i  (io_beat),
        .cnt_o  (starve_cnt)
    );

    sat_counter #(
        .Width (BW),
        .Limit (BW'(BURSTMAX))
    ) u_burst_cnt (
        .clk_i  (clock),
        .rst_ni (reset),
        .inc_i  (io_beat && cpuReq),
        .clr_i  ((state_d != IO_BURST) || (io_beat && !cpuReq)),
        .cnt_o  (burst_cnt)
    );

`ifdef DMEM_ARB_STATS_EN
    sat_counter #(
        .Width (STAT_WIDTH)
    ) u_stat_stall (
        .clk_i  (clock),
        .rst_ni (reset),
        .inc_i  (cpuStall),
        .clr_i  (1'b0),
        .cnt_o  (statCpuStall)
    );

    sat_counter #(
        .Width (STAT_WIDTH)
    ) u_stat_beats (
        .clk_i  (clock),
        .rst_ni (reset),
        .inc_i  (io_beat),
        .clr_i  (1'b0),
        .cnt_o  (statIoBeats)
    );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, hand sequences and a read-return scoreboard.
module tb_dmem_arbiter;

    localparam int unsigned W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         cpuReq = 1'b0, cpuWe = 1'b0, ioReq = 1'b0, ioWe = 1'b0;
    logic [W-1:0] cpuAddr = '0, cpuWData = '0, ioAddr = '0, ioWData = '0;
    logic         cpuStall, ioGnt, ioRValid, memWe;
    logic [W-1:0] cpuRData, ioRData, memAddr, memWData, memRData;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0]  statCpuStall, statIoBeats;
`endif

    always #5 clock = ~clock;

    dmem_arbiter #(
        .WIDTH       (W),
        .STARVELIMIT (8),
        .BURSTMAX    (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cpuReq       (cpuReq),
        .cpuWe        (cpuWe),
        .cpuAddr      (cpuAddr),
        .cpuWData     (cpuWData),
        .cpuStall     (cpuStall),
        .cpuRData     (cpuRData),
        .ioReq        (ioReq),
        .ioWe         (ioWe),
        .ioAddr       (ioAddr),
        .ioWData      (ioWData),
        .ioGnt        (ioGnt),
        .ioRValid     (ioRValid),
        .ioRData      (ioRData),
        .memWe        (memWe),
        .memAddr      (memAddr),
        .memWData     (memWData),
`ifdef DMEM_ARB_STATS_EN
        .statCpuStall (statCpuStall),
        .statIoBeats  (statIoBeats),
`endif
        .memRData     (memRData)
    );

    // Synchronous-read memory: writes on the edge, read data one cycle after address.
    logic [W-1:0] mem [256];
    always @(posedge clock) begin
        if (memWe) mem[memAddr[7:0]] <= memWData;
        memRData <= mem[memAddr[7:0]];
    end

    typedef struct {
        logic         cq, cw;
        logic [W-1:0] ca, cd;
        logic         iq, iw;
        logic [W-1:0] ia, id;
        logic         gnt, stall, we;
        logic [W-1:0] addr, wdata;
        logic         rv;
        logic [W-1:0] rdata;
        logic         crv;
        logic [W-1:0] crdata;
    } vec_t;

    typedef struct {
        logic         rv;
        logic [W-1:0] rdata;
        logic         crv;
        logic [W-1:0] crdata;
    } ret_t;

    ret_t sb[$];
    vec_t tbl[10];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic cq, input logic cw, input logic [W-1:0] ca,
                                input logic [W-1:0] cd, input logic iq, input logic iw,
                                input logic [W-1:0] ia, input logic [W-1:0] id,
                                input logic gnt, input logic stall, input logic we,
                                input logic [W-1:0] addr, input logic [W-1:0] wdata,
                                input logic rv, input logic [W-1:0] rdata,
                                input logic crv, input logic [W-1:0] crdata);
        vec_t v;
        v.cq = cq; v.cw = cw; v.ca = ca; v.cd = cd;
        v.iq = iq; v.iw = iw; v.ia = ia; v.id = id;
        v.gnt = gnt; v.stall = stall; v.we = we; v.addr = addr; v.wdata = wdata;
        v.rv = rv; v.rdata = rdata; v.crv = crv; v.crdata = crdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, want %b", name, got, exp);
        end
    endtask

    // Drive one cycle, check the combinational grant/mux, and retire last cycle's read return.
    task automatic apply(input vec_t v, input string tag);
        ret_t r;
        @(posedge clock);
        #1;
        cpuReq = v.cq; cpuWe = v.cw; cpuAddr = v.ca; cpuWData = v.cd;
        ioReq  = v.iq; ioWe  = v.iw; ioAddr  = v.ia; ioWData  = v.id;
        @(negedge clock);
        chk1({tag, ".ioGnt"}, ioGnt, v.gnt);
        chk1({tag, ".cpuStall"}, cpuStall, v.stall);
        chk1({tag, ".memWe"}, memWe, v.we);
        chk({tag, ".memAddr"}, memAddr, v.addr);
        chk({tag, ".memWData"}, memWData, v.wdata);
        if (sb.size() == 0) begin
            chk1({tag, ".scoreboard_empty"}, 1'b1, 1'b0);
        end else begin
            r = sb.pop_front();
            chk1({tag, ".ioRValid"}, ioRValid, r.rv);
            if (r.rv) chk({tag, ".ioRData"}, ioRData, r.rdata);
            if (r.crv) chk({tag, ".cpuRData"}, cpuRData, r.crdata);
        end
        sb.push_back('{v.rv, v.rdata, v.crv, v.crdata});
    endtask

    task automatic do_reset(input string tag);
        @(posedge clock);
        #1;
        reset = 1'b0;
        cpuReq = 1'b1; cpuWe = 1'b1; ioReq = 1'b1; ioWe = 1'b0;
        #2;
        chk1({tag, ".rst_ioRValid"}, ioRValid, 1'b0);
        chk1({tag, ".rst_ioGnt"}, ioGnt, 1'b0);
        chk1({tag, ".rst_memWe"}, memWe, 1'b0);
        chk1({tag, ".rst_cpuStall"}, cpuStall, 1'b0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        cpuReq = 1'b0; cpuWe = 1'b0; ioReq = 1'b0; ioWe = 1'b0;
        #1;
        reset = 1'b1;
        sb.delete();
        sb.push_back('{1'b0, '0, 1'b0, '0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic g;
        tbl[0] = mk(1'b0, 1'b0, 32'h100, 32'h77, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b0, 32'h100, 32'h77, 1'b0, 32'h0, 1'b0, 32'h0);
        tbl[1] = mk(1'b1, 1'b1, 32'h20, 32'h11, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b1, 32'h20, 32'h11, 1'b0, 32'h0, 1'b0, 32'h0);
        tbl[2] = mk(1'b0, 1'b0, 32'h100, 32'h77, 1'b1, 1'b1, 32'h10, 32'hABCD,
                    1'b1, 1'b0, 1'b1, 32'h10, 32'hABCD, 1'b0, 32'h0, 1'b0, 32'h0);
        tbl[3] = mk(1'b0, 1'b0, 32'h100, 32'h77, 1'b1, 1'b0, 32'h10, 32'h99,
                    1'b1, 1'b0, 1'b0, 32'h10, 32'h99, 1'b1, 32'hABCD, 1'b0, 32'h0);
        tbl[4] = mk(1'b1, 1'b0, 32'h10, 32'h55, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b0, 32'h10, 32'h55, 1'b0, 32'h0, 1'b1, 32'hABCD);
        tbl[5] = mk(1'b1, 1'b0, 32'h40, 32'h66, 1'b1, 1'b1, 32'h50, 32'h5,
                    1'b0, 1'b0, 1'b0, 32'h40, 32'h66, 1'b0, 32'h0, 1'b0, 32'h0);
        tbl[6] = mk(1'b0, 1'b0, 32'h100, 32'h77, 1'b1, 1'b1, 32'h50, 32'h5,
                    1'b1, 1'b0, 1'b1, 32'h50, 32'h5, 1'b0, 32'h0, 1'b0, 32'h0);
        tbl[7] = mk(1'b1, 1'b0, 32'h70, 32'h1, 1'b1, 1'b1, 32'h60, 32'h6,
                    1'b1, 1'b1, 1'b1, 32'h60, 32'h6, 1'b0, 32'h0, 1'b0, 32'h0);
        tbl[8] = mk(1'b1, 1'b1, 32'h80, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b1, 32'h80, 32'h8, 1'b0, 32'h0, 1'b0, 32'h0);
        tbl[9] = mk(1'b0, 1'b1, 32'h90, 32'h9, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b0, 32'h90, 32'h9, 1'b0, 32'h0, 1'b0, 32'h0);

        do_reset("init");

        for (int i = 0; i < 10; i++) begin
            apply(tbl[i], $sformatf("tbl%0d", i));
        end

        // CPU alone: never stalled, always owns the port.
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] a;
            logic         w;
            a = 32'h200 + 4 * i;
            w = i[0];
            apply(mk(1'b1, w, a, i, 1'b0, 1'b0, 32'h0, 32'h0,
                     1'b0, 1'b0, w, a, i, 1'b0, 32'h0, 1'b0, 32'h0),
                  $sformatf("cpu_only%0d", i));
        end

        // I/O read beat, then reset in the following cycle: the read return is dropped.
        apply(mk(1'b0, 1'b0, 32'h100, 32'h77, 1'b1, 1'b0, 32'h10, 32'h0,
                 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 32'hABCD, 1'b0, 32'h0), "mid_burst_rd");
        do_reset("mid_burst");

        // Continuous contention: 8 denied cycles, 4 beats, 1 yield cycle, repeating.
        for (int c = 1; c <= 30; c++) begin
            logic [W-1:0] ca;
            ca = 32'h300 + c;
            g  = (c >= 9) && (((c - 9) % 12) < 4);
            apply(mk(1'b1, 1'b0, ca, 32'h0, 1'b1, 1'b1, 32'hA0, 32'h1234,
                     g, g, g, g ? 32'hA0 : ca, g ? 32'h1234 : 32'h0,
                     1'b0, 32'h0, 1'b0, 32'h0),
                  $sformatf("starve%0d", c));
`ifdef DMEM_ARB_STATS_EN
            if (c == 11) begin
                chk("stat.statIoBeats", statIoBeats, 32'd2);
                chk("stat.statCpuStall", statCpuStall, 32'd2);
            end
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
